// File: rtl/pep_mmacc_body_ram_mc.sv
// pep_mmacc_body_ram_mc
// Multi-channel MMACC body store. Holds the LWE body b and an accumulated
// KS mod-switch error per PID. RD_CH_NB requesters are served round-robin.
// Each read returns b, mean-compensated and mod-switched down to COEF_W bits,
// tagged with the channel that requested it.
module pep_mmacc_body_ram_mc #(
  parameter  int PID_NB    = 64,
  parameter  int MOD_W     = 32,
  parameter  int ERR_W     = 12,
  parameter  int MEAN_F    = 4,
  parameter  int KEY_MEAN  = 8,
  parameter  int COL_NB    = 4,
  parameter  int COEF_W    = 12,
  parameter  int RD_CH_NB  = 2,
  parameter  int OUT_DEPTH = 4,
  localparam int PID_W     = $clog2(PID_NB),
  localparam int CH_W      = (RD_CH_NB > 1) ? $clog2(RD_CH_NB) : 1
) (
  input  logic                         clk,
  input  logic                         s_rst_n,
  input  logic                         reset_cache,
  input  logic                         wr_en,
  input  logic [PID_W-1:0]             wr_pid,
  input  logic [MOD_W-1:0]             wr_data,
  input  logic                         corr_wr_en,
  input  logic [PID_W-1:0]             corr_wr_pid,
  input  logic [ERR_W-1:0]             corr_wr_data,
  input  logic [RD_CH_NB*PID_W-1:0]    rd_pid,
  input  logic [RD_CH_NB-1:0]          rd_vld,
  output logic [RD_CH_NB-1:0]          rd_rdy,
  output logic [COEF_W-1:0]            out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         err_sticky
);

  localparam int W     = MOD_W + MEAN_F;
  localparam int CNT_W = (COL_NB > 1) ? $clog2(COL_NB) : 1;
  localparam int CRD_W = $clog2(OUT_DEPTH + 1);
  localparam int FP_W  = $clog2(OUT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COL_NB - 1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(OUT_DEPTH);
  localparam logic [FP_W-1:0]  FP_LAST  = FP_W'(OUT_DEPTH - 1);

  // (b << MEAN_F) - sext(acc) * KEY_MEAN, wrapping modulo 2^W
  function automatic logic [W-1:0] mean_comp(input logic [MOD_W-1:0] b,
                                             input logic [ERR_W-1:0] acc);
    logic [W-1:0] b_sh;
    logic [W-1:0] acc_ext;
    logic [W-1:0] mean_term;
    b_sh      = {b, {MEAN_F{1'b0}}};
    acc_ext   = {{(W-ERR_W){acc[ERR_W-1]}}, acc};
    mean_term = acc_ext * W'(KEY_MEAN);
    return b_sh - mean_term;
  endfunction

  // Keep the top COEF_W bits and round half up; a carry out of the top bit wraps
  function automatic logic [COEF_W-1:0] round_coef(input logic [W-1:0] c);
    return c[W-1 -: COEF_W] + {{(COEF_W-1){1'b0}}, c[W-1-COEF_W]};
  endfunction

  // Storage. The data RAMs are never reset; only the flags are.
  logic [MOD_W-1:0]  body_mem [PID_NB];
  logic [ERR_W-1:0]  acc_mem  [PID_NB];
  logic [CNT_W-1:0]  cnt_mem  [PID_NB];
  logic [PID_NB-1:0] present_r;
  logic [PID_NB-1:0] corr_present_r;
  logic              err_sticky_r;

  // s0 write stage
  logic              wr_en_r;
  logic [PID_W-1:0]  wr_pid_r;
  logic [MOD_W-1:0]  wr_data_r;
  logic              corr_en_r;
  logic [PID_W-1:0]  corr_pid_r;
  logic [ERR_W-1:0]  corr_data_r;
  logic              body_diff_s;
  logic              corr_first_s;
  logic              corr_full_s;

  // Arbitration
  logic [CH_W-1:0]     ptr_r;
  logic [CRD_W-1:0]    credit_r;
  logic [RD_CH_NB-1:0] elig_s;
  logic                grant_en_s;
  logic                grant_vld_s;
  logic [CH_W-1:0]     grant_ch_s;
  logic [PID_W-1:0]    grant_pid_s;
  logic                take_s;
  int                  idx_s;

  // Read pipeline and output FIFO
  logic              rq_vld_r;
  logic [CH_W-1:0]   rq_ch_r;
  logic [MOD_W-1:0]  rq_body_r;
  logic [ERR_W-1:0]  rq_acc_r;
  logic              s1_vld_r;
  logic [CH_W-1:0]   s1_ch_r;
  logic [W-1:0]      s1_corr_r;
  logic [COEF_W-1:0] fifo_data_mem [OUT_DEPTH];
  logic [CH_W-1:0]   fifo_ch_mem   [OUT_DEPTH];
  logic [FP_W-1:0]   wp_r;
  logic [FP_W-1:0]   rp_r;
  logic [CRD_W-1:0]  fcnt_r;
  logic              push_s;
  logic              pop_s;

  // Register the incoming writes into s0; only the enables need a reset
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      wr_en_r   <= 1'b0;
      corr_en_r <= 1'b0;
    end else begin
      wr_en_r   <= wr_en;
      corr_en_r <= corr_wr_en;
    end
  end

  // Write address and data of s0 (no reset needed)
  always_ff @(posedge clk) begin
    wr_pid_r    <= wr_pid;
    wr_data_r   <= wr_data;
    corr_pid_r  <= corr_wr_pid;
    corr_data_r <= corr_wr_data;
  end

  // Classify the s0 writes against the current entry state
  always_comb begin
    body_diff_s  = present_r[wr_pid_r] && (body_mem[wr_pid_r] != wr_data_r);
    corr_first_s = !corr_present_r[corr_pid_r];
    corr_full_s  = corr_present_r[corr_pid_r] && (cnt_mem[corr_pid_r] == CNT_LAST);
  end

  // Update the data RAMs. A corr write past the last column leaves the entry unchanged.
  always_ff @(posedge clk) begin
    if (wr_en_r) begin
      body_mem[wr_pid_r] <= wr_data_r;
    end
    if (corr_en_r && corr_first_s) begin
      acc_mem[corr_pid_r] <= corr_data_r;
      cnt_mem[corr_pid_r] <= {CNT_W{1'b0}};
    end else if (corr_en_r && !corr_full_s) begin
      acc_mem[corr_pid_r] <= acc_mem[corr_pid_r] + corr_data_r;
      cnt_mem[corr_pid_r] <= cnt_mem[corr_pid_r] + CNT_W'(1);
    end
  end

  // Update the presence flags: set by writes, cleared by reset_cache or by an accepted read
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      present_r      <= {PID_NB{1'b0}};
      corr_present_r <= {PID_NB{1'b0}};
    end else begin
      if (reset_cache) begin
        present_r      <= {PID_NB{1'b0}};
        corr_present_r <= {PID_NB{1'b0}};
      end else if (grant_vld_s) begin
        present_r[grant_pid_s]      <= 1'b0;
        corr_present_r[grant_pid_s] <= 1'b0;
      end
      if (wr_en_r) begin
        present_r[wr_pid_r] <= 1'b1;
      end
      if (corr_en_r && corr_first_s) begin
        corr_present_r[corr_pid_r] <= 1'b1;
      end
    end
  end

  // Sticky error: a differing body rewrite or a corr write past the last column
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      err_sticky_r <= 1'b0;
    end else if ((wr_en_r && body_diff_s) || (corr_en_r && corr_full_s)) begin
      err_sticky_r <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_r;

  // Per-channel eligibility: the entry must have its body and all of its corr columns
  always_comb begin
    elig_s = {RD_CH_NB{1'b0}};
    for (int c = 0; c < RD_CH_NB; c++) begin
      elig_s[c] = rd_vld[c]
                & present_r[rd_pid[c*PID_W +: PID_W]]
                & corr_present_r[rd_pid[c*PID_W +: PID_W]]
                & (cnt_mem[rd_pid[c*PID_W +: PID_W]] == CNT_LAST);
    end
  end

  // No grant while a write sits in s0, in reset, or when every output slot is already spoken for
  assign grant_en_s = s_rst_n & ~wr_en_r & ~corr_en_r & (credit_r != CRD_MAX);

  // Round-robin pick: the first eligible channel at or after ptr
  always_comb begin
    grant_vld_s = 1'b0;
    grant_ch_s  = {CH_W{1'b0}};
    take_s      = 1'b0;
    idx_s       = 32'sd0;
    for (int i = 0; i < RD_CH_NB; i++) begin
      idx_s       = (int'(ptr_r) + i) % RD_CH_NB;
      take_s      = grant_en_s & ~grant_vld_s & elig_s[idx_s];
      grant_ch_s  = take_s ? CH_W'(idx_s) : grant_ch_s;
      grant_vld_s = grant_vld_s | take_s;
    end
  end

  assign grant_pid_s = rd_pid[int'(grant_ch_s)*PID_W +: PID_W];

  // Ready is asserted only toward the channel being granted
  always_comb begin
    rd_rdy             = {RD_CH_NB{1'b0}};
    rd_rdy[grant_ch_s] = grant_vld_s;
  end

  assign out_vld = (fcnt_r != {CRD_W{1'b0}});
  assign pop_s   = out_vld & out_rdy;
  assign push_s  = s1_vld_r;

  // Arbiter pointer and read credit (reads granted but not yet popped)
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      ptr_r    <= {CH_W{1'b0}};
      credit_r <= {CRD_W{1'b0}};
    end else begin
      if (grant_vld_s) begin
        ptr_r <= CH_W'((int'(grant_ch_s) + 1) % RD_CH_NB);
      end
      case ({grant_vld_s, pop_s})
        2'b10:   credit_r <= credit_r + CRD_W'(1);
        2'b01:   credit_r <= credit_r - CRD_W'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Pipeline valids; a reset flushes every read in flight
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      rq_vld_r <= 1'b0;
      s1_vld_r <= 1'b0;
    end else begin
      rq_vld_r <= grant_vld_s;
      s1_vld_r <= rq_vld_r;
    end
  end

  // Pipeline data: RAM read at the grant, then the mean compensation
  always_ff @(posedge clk) begin
    rq_ch_r   <= grant_ch_s;
    rq_body_r <= body_mem[grant_pid_s];
    rq_acc_r  <= acc_mem[grant_pid_s];
    s1_ch_r   <= rq_ch_r;
    s1_corr_r <= mean_comp(rq_body_r, rq_acc_r);
  end

  // FIFO pointers and occupancy. The credit limit guarantees a push never finds the FIFO full.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      wp_r   <= {FP_W{1'b0}};
      rp_r   <= {FP_W{1'b0}};
      fcnt_r <= {CRD_W{1'b0}};
    end else begin
      if (push_s) begin
        wp_r <= (wp_r == FP_LAST) ? {FP_W{1'b0}} : wp_r + FP_W'(1);
      end
      if (pop_s) begin
        rp_r <= (rp_r == FP_LAST) ? {FP_W{1'b0}} : rp_r + FP_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fcnt_r <= fcnt_r + CRD_W'(1);
        2'b01:   fcnt_r <= fcnt_r - CRD_W'(1);
        default: fcnt_r <= fcnt_r;
      endcase
    end
  end

  // FIFO storage: the rounded coefficient and its channel
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_mem[wp_r] <= round_coef(s1_corr_r);
      fifo_ch_mem[wp_r]   <= s1_ch_r;
    end
  end

  assign out_data = fifo_data_mem[rp_r];
  assign out_ch   = fifo_ch_mem[rp_r];

endmodule
